// File: rtl/tft_frame_pkg.sv
// tft_frame_pkg: frame geometry and RGB565 pixel layout shared by the frame writer and TFT scan controller
package tft_frame_pkg;
   localparam int IMG_W = 800;
   localparam int IMG_H = 480;
   localparam int PIX_TOTAL = IMG_W * IMG_H;
   localparam int ADDR_W = 19;
   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;
   typedef struct packed {
      logic [R_MSB-R_LSB:0] r;
      logic [G_MSB-G_LSB:0] g;
      logic [B_MSB-B_LSB:0] b;
   } rgb565_t;
   typedef enum logic {S_HI, S_LO} wr_state_e;
endpackage

// File: rtl/byte_gap_timer.sv
// byte_gap_timer: idle-gap counter; tc pulses as the count steps onto TIMEOUT-1 unless cleared that cycle
module byte_gap_timer
   import tft_frame_pkg::*;
#(
   parameter int TIMEOUT = 33000
) (
   input  logic clk_33M,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign tc = en && !clr && cnt == CW'(TIMEOUT - 2);
   always_ff @(posedge clk_33M or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
endmodule

// File: rtl/uart_frame_writer.sv
// uart_frame_writer: packs UART byte pairs into RGB565 pixels and writes them in raster order to frame RAM
module uart_frame_writer
   import tft_frame_pkg::*;
#(
   parameter int IMG_W   = tft_frame_pkg::IMG_W,
   parameter int IMG_H   = tft_frame_pkg::IMG_H,
   parameter int ADDR_W  = tft_frame_pkg::ADDR_W,
   parameter int TIMEOUT = 33000
) (
   input  logic              clk_33M,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              timeout_err
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
   wr_state_e state, state_n;
   logic [7:0] hi;
   logic [ADDR_W-1:0] addr;
   logic tc, wr, last;
   byte_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
      .clk_33M (clk_33M),
      .rst_n   (rst_n),
      .clr     (rx_done),
      .en      (busy & ~rx_done),
      .tc      (tc)
   );
   always_ff @(posedge clk_33M or negedge rst_n)
      if (!rst_n) state <= S_HI;
      else state <= state_n;
   always_comb begin
      state_n = tc ? S_HI : rx_done ? (state == S_HI ? S_LO : S_HI) : state;
      wr = rx_done && state == S_LO;
      last = wr && addr == LAST;
   end
   // a timeout and a byte never coincide: the timer is gated off by rx_done
   always_ff @(posedge clk_33M or negedge rst_n)
      if (!rst_n) begin
         hi <= '0;
         addr <= '0;
         busy <= 1'b0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         frame_done <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         wr_en <= wr;
         frame_done <= last;
         timeout_err <= tc;
         if (rx_done && state == S_HI) hi <= rx_data;
         if (wr) begin
            wr_addr <= addr;
            wr_data <= {hi, rx_data};
         end
         addr <= (tc || last) ? '0 : wr ? addr + ADDR_W'(1) : addr;
         busy <= (tc || last) ? 1'b0 : rx_done ? 1'b1 : busy;
      end
endmodule

// File: tb/tb_uart_frame_writer.sv
// tb_uart_frame_writer: directed checks of pixel packing, framing, gap timeout and reset behaviour on a 4x2 frame
module tb_uart_frame_writer;
   localparam int IMG_W = 4;
   localparam int IMG_H = 2;
   localparam int ADDR_W = 3;
   localparam int TIMEOUT = 100;
   localparam int PIX = IMG_W * IMG_H;
   logic clk_33M = 1'b0;
   logic rst_n = 1'b0;
   logic rx_done = 1'b0;
   logic [7:0] rx_data = '0;
   logic wr_en, busy, frame_done, timeout_err;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0] wr_data;
   int errors = 0, checks = 0;
   int n_wr = 0, n_fd = 0, n_to = 0, gaps = 0, exp_next = 0;
   int fired, w0, f0, t0;
   bit track = 1'b0;
   logic [15:0] frame_px [PIX] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                                   16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A};
   always #15 clk_33M = ~clk_33M;
   uart_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_33M     (clk_33M),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err)
   );
   always @(negedge clk_33M)
      if (rst_n) begin
         if (wr_en) begin
            n_wr++;
            if (track && int'(wr_addr) != exp_next) gaps++;
            exp_next = (int'(wr_addr) + 1) % PIX;
         end
         if (frame_done) n_fd++;
         if (timeout_err) n_to++;
      end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_33M);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk_33M);
      rx_done = 1'b0;
   endtask
   task automatic send_pixel(input logic [15:0] px);
      send_byte(px[15:8]);
      send_byte(px[7:0]);
   endtask
   task automatic check_write(input string tag, input int a, input logic [15:0] d, input logic fd, input logic b);
      check({tag, " wr_en"}, wr_en, 1);
      check({tag, " wr_addr"}, wr_addr, a);
      check({tag, " wr_data"}, wr_data, d);
      check({tag, " frame_done"}, frame_done, fd);
      check({tag, " busy"}, busy, b);
      check({tag, " timeout_err"}, timeout_err, 0);
   endtask
   task automatic check_idle_zero(input string tag);
      check({tag, " outputs"}, {wr_en, busy, frame_done, timeout_err, wr_data, 5'b0, wr_addr}, 0);
   endtask
   initial begin
      #1 check_idle_zero("reset");
      repeat (3) @(negedge clk_33M);
      rst_n = 1'b1;
      @(negedge clk_33M);
      check_idle_zero("post_reset");
      send_pixel(16'hF800);
      check_write("first", 0, 16'hF800, 0, 1);
      @(negedge clk_33M);
      check("first hold wr_en", wr_en, 0);
      check("first hold addr", wr_addr, 0);
      check("first hold data", wr_data, 16'hF800);
      for (int i = 1; i < PIX; i++) begin
         send_pixel(frame_px[i]);
         check_write($sformatf("px%0d", i), i, frame_px[i], i == PIX - 1, i != PIX - 1);
      end
      send_pixel(16'hABCD);
      check_write("wrap", 0, 16'hABCD, 0, 1);
      send_pixel(16'h1122);
      check_write("px1b", 1, 16'h1122, 0, 1);
      send_byte(8'h55);
      fired = 0;
      for (int c = 1; c <= TIMEOUT + 5; c++) begin
         if (fired == 0 && timeout_err) begin
            fired = c;
            check("timeout busy", busy, 0);
            check("timeout frame_done", frame_done, 0);
         end
         @(negedge clk_33M);
      end
      check("timeout cycle", fired, TIMEOUT);
      #1 check("timeout count", n_to, 1);
      send_pixel(16'h1234);
      check_write("after_timeout", 0, 16'h1234, 0, 1);
      send_byte(8'h56);
      repeat (TIMEOUT - 3) @(negedge clk_33M);
      #1 t0 = n_to;
      send_byte(8'h78);
      check_write("terminal", 1, 16'h5678, 0, 1);
      #1 check("terminal no timeout", n_to, t0);
      repeat (TIMEOUT + 5) @(negedge clk_33M);
      #1 check("late timeout count", n_to, t0 + 1);
      check("late timeout busy", busy, 0);
      send_pixel(16'h0102);
      send_pixel(16'h0304);
      send_pixel(16'h0506);
      check_write("pre_reset px2", 2, 16'h0506, 0, 1);
      send_byte(8'h07);
      #5 rst_n = 1'b0;
      #1 check_idle_zero("mid_reset");
      repeat (3) @(negedge clk_33M);
      rst_n = 1'b1;
      #1 t0 = n_to;
      repeat (TIMEOUT + 20) @(negedge clk_33M);
      #1 check("reset no timeout", n_to, t0);
      check("reset idle busy", busy, 0);
      send_pixel(16'h9ABC);
      check_write("after_reset", 0, 16'h9ABC, 0, 1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk_33M);
      rst_n = 1'b1;
      #1 begin
         w0 = n_wr;
         f0 = n_fd;
         t0 = n_to;
         exp_next = 0;
         gaps = 0;
         track = 1'b1;
      end
      for (int p = 0; p < 2 * PIX; p++) send_pixel({p[7:0], ~p[7:0]});
      check("b2b last addr", wr_addr, PIX - 1);
      check("b2b last data", wr_data, 16'h0FF0);
      @(negedge clk_33M);
      #1 check("b2b writes", n_wr - w0, 2 * PIX);
      check("b2b frame_done", n_fd - f0, 2);
      check("b2b gaps", gaps, 0);
      check("b2b timeouts", n_to, t0);
      check("b2b busy", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
